// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared states, board size default and pattern encodings for the life sequencer.
package life_pkg;

    localparam int BOARD_BITS_DEF = 6;
    localparam int PAT_ADDR_BITS  = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COPY,
        ST_EVAL,
        ST_FLUSH
    } state_e;

    localparam logic [1:0] PAT_CLEAR   = 2'd0;
    localparam logic [1:0] PAT_UW      = 2'd1;
    localparam logic [1:0] PAT_GLIDER  = 2'd2;
    localparam logic [1:0] PAT_CHECKER = 2'd3;

    // 8x8 bitmaps, bit index = row*8 + col
    localparam logic [63:0] PAT_UW_BITS      = 64'h50A8_8888_0609_0909;
    localparam logic [63:0] PAT_GLIDER_BITS  = 64'h0000_0000_0007_0402;
    localparam logic [63:0] PAT_CHECKER_BITS = 64'hAA55_AA55_AA55_AA55;

endpackage

// File: rtl/life_pattern_rom.sv
// rtl/life_pattern_rom.sv - combinational pattern ROM indexed by {pattern select, cell address}.
module life_pattern_rom
    import life_pkg::*;
#(
    parameter int ADDR_BITS = BOARD_BITS_DEF
) (
    input  logic [1:0]           sel_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    output logic                 data_o
);

    logic [PAT_ADDR_BITS-1:0] idx;
    logic [63:0]              bits;

    always_comb begin
        idx  = PAT_ADDR_BITS'(addr_i);
        bits = '0;
        case (sel_i)
            PAT_CLEAR:   bits = '0;
            PAT_UW:      bits = PAT_UW_BITS;
            PAT_GLIDER:  bits = PAT_GLIDER_BITS;
            PAT_CHECKER: bits = PAT_CHECKER_BITS;
        endcase
        data_o = bits[idx];
    end

endmodule

// File: rtl/life_sequencer.sv
// rtl/life_sequencer.sv - sweep sequencer driving load/copy/evaluate passes over the life board.
module life_sequencer
    import life_pkg::*;
#(
    parameter int BOARD_BITS = BOARD_BITS_DEF,
    parameter int SPEED_BITS = 3
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  frame_tick_i,
    input  logic                  run_i,
    input  logic                  step_i,
    input  logic                  load_i,
    input  logic [1:0]            pattern_sel_i,
    input  logic [SPEED_BITS-1:0] speed_i,
    output logic [BOARD_BITS-1:0] rd_addr_o,
    output logic [BOARD_BITS-1:0] wr_addr_o,
    output logic                  copy_we_o,
    output logic                  eval_we_o,
    output logic                  load_we_o,
    output logic                  load_data_o,
    output logic                  show_prev_o,
    output logic                  busy_o,
    output logic                  gen_done_o,
    output logic [15:0]           gen_count_o
);

    localparam logic [BOARD_BITS-1:0] LAST_ADDR = '1;

    state_e                state_q, state_d;
    logic [BOARD_BITS-1:0] addr_q, addr_d, wr_addr_q;
    logic [SPEED_BITS-1:0] div_q, div_d;
    logic [1:0]            sel_q, sel_d;
    logic [15:0]           gen_count_q, gen_count_d;
    logic                  copy_we_q, eval_we_q, load_we_q;
    logic                  idle, sweeping, last, go, gen_end;

    always_comb begin
        idle     = (state_q == ST_IDLE);
        sweeping = (state_q == ST_LOAD) || (state_q == ST_COPY) || (state_q == ST_EVAL);
        last     = sweeping && (addr_q == LAST_ADDR);
        // >= rather than == so a lowered speed fires on the next tick
        go       = idle && run_i && frame_tick_i && (div_q >= speed_i);
        // FLUSH after EVAL is the only FLUSH carrying the final eval write
        gen_end  = (state_q == ST_FLUSH) && eval_we_q;

        state_d     = state_q;
        addr_d      = sweeping ? addr_q + BOARD_BITS'(1) : '0;
        div_d       = div_q;
        sel_d       = sel_q;
        gen_count_d = gen_count_q + 16'(gen_end);

        if (idle && run_i && frame_tick_i) begin
            div_d = go ? '0 : div_q + SPEED_BITS'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (load_i) begin
                    state_d = ST_LOAD;
                    sel_d   = pattern_sel_i;
                end else if (go || (step_i && !run_i)) begin
                    state_d = ST_COPY;
                end
            end
            ST_LOAD:  if (last) state_d = ST_FLUSH;
            ST_COPY:  if (last) state_d = ST_EVAL;
            ST_EVAL:  if (last) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        busy_o      = !idle;
        gen_done_o  = gen_end;
        show_prev_o = (state_q == ST_COPY) || (state_q == ST_EVAL) || gen_end;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wr_addr_q   <= '0;
            copy_we_q   <= 1'b0;
            eval_we_q   <= 1'b0;
            load_we_q   <= 1'b0;
            div_q       <= '0;
            sel_q       <= PAT_CLEAR;
            gen_count_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wr_addr_q   <= addr_q;
            copy_we_q   <= (state_q == ST_COPY);
            eval_we_q   <= (state_q == ST_EVAL);
            load_we_q   <= (state_q == ST_LOAD);
            div_q       <= div_d;
            sel_q       <= sel_d;
            gen_count_q <= gen_count_d;
        end
    end

    life_pattern_rom #(
        .ADDR_BITS (BOARD_BITS)
    ) u_rom (
        .sel_i  (sel_q),
        .addr_i (wr_addr_q),
        .data_o (load_data_o)
    );

    assign rd_addr_o   = addr_q;
    assign wr_addr_o   = wr_addr_q;
    assign copy_we_o   = copy_we_q;
    assign eval_we_o   = eval_we_q;
    assign load_we_o   = load_we_q;
    assign gen_count_o = gen_count_q;

endmodule

// File: tb/tb_life_sequencer.sv
// tb/tb_life_sequencer.sv - directed vector and sequence bench for life_sequencer.
module tb_life_sequencer;

    logic        clk = 1'b0;
    logic        reset, frame_tick, run, step, load;
    logic [1:0]  pattern_sel;
    logic [2:0]  speed;
    logic [5:0]  rd_addr, wr_addr;
    logic        copy_we, eval_we, load_we, load_data, show_prev, busy, gen_done;
    logic [15:0] gen_count;

    int n_checks = 0;
    int n_fail = 0;
    int onehot_viol = 0;
    int sp_viol = 0;

    typedef struct {
        logic       rst, ftick, run, step, load;
        logic [1:0] sel;
        logic [5:0] e_rd, e_wr;
        logic       e_cwe, e_ewe, e_lwe, e_ld, e_busy, e_sp;
    } vec_t;

    vec_t vt[11];

    always #5 clk = ~clk;

    life_sequencer dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .frame_tick_i  (frame_tick),
        .run_i         (run),
        .step_i        (step),
        .load_i        (load),
        .pattern_sel_i (pattern_sel),
        .speed_i       (speed),
        .rd_addr_o     (rd_addr),
        .wr_addr_o     (wr_addr),
        .copy_we_o     (copy_we),
        .eval_we_o     (eval_we),
        .load_we_o     (load_we),
        .load_data_o   (load_data),
        .show_prev_o   (show_prev),
        .busy_o        (busy),
        .gen_done_o    (gen_done),
        .gen_count_o   (gen_count)
    );

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (int'(copy_we) + int'(eval_we) + int'(load_we) > 1) onehot_viol++;
            if ((copy_we || eval_we) && !show_prev) sp_viol++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset();
        reset = 1'b1; frame_tick = 1'b0; step = 1'b0; load = 1'b0; run = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1; cyc(); step = 1'b0;
    endtask

    int          uw_ones[17] = '{0, 3, 8, 11, 16, 19, 25, 26, 35, 39, 43, 47, 51, 53, 55, 60, 62};
    logic [63:0] mask, exp_mask;
    int          cnt, cnt2, cnt3, addr_err, last_copy, first_eval, found;

    initial begin
        reset = 1'b1; frame_tick = 1'b0; run = 1'b0; step = 1'b0; load = 1'b0;
        pattern_sel = 2'd0; speed = 3'd0;

        //            rst   tick  run   step  load  sel    rd     wr     cwe   ewe   lwe   ld    busy  sp
        vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 6'd1, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 6'd2, 6'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 6'd3, 6'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 6'd4, 6'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 6'd1, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        cyc();
        for (int i = 0; i < 11; i++) begin
            reset = vt[i].rst; frame_tick = vt[i].ftick; run = vt[i].run;
            step = vt[i].step; load = vt[i].load; pattern_sel = vt[i].sel;
            cyc();
            chk($sformatf("vec%0d", i),
                {rd_addr, wr_addr, copy_we, eval_we, load_we, load_data, busy, show_prev},
                {vt[i].e_rd, vt[i].e_wr, vt[i].e_cwe, vt[i].e_ewe, vt[i].e_lwe,
                 vt[i].e_ld, vt[i].e_busy, vt[i].e_sp});
        end

        // UW glyph load, pattern_sel changed right after acceptance
        do_reset();
        pattern_sel = 2'd1; load = 1'b1; cyc(); load = 1'b0; pattern_sel = 2'd0;
        cnt = 0; addr_err = 0; mask = '0;
        for (int c = 0; c < 80; c++) begin
            cyc();
            if (load_we) begin
                if (wr_addr != 6'(cnt)) addr_err++;
                mask[wr_addr] = load_data;
                cnt++;
            end
        end
        exp_mask = '0;
        foreach (uw_ones[k]) exp_mask[uw_ones[k]] = 1'b1;
        chk("load_we_cycles", cnt, 64);
        chk("load_wr_addr_seq", addr_err, 0);
        chk("uw_pattern", mask, exp_mask);
        chk("load_gen_count", gen_count, 0);
        chk("load_back_idle", busy, 0);

        // free-running, speed 0
        do_reset();
        run = 1'b1; speed = 3'd0;
        pulse_tick();
        chk("copy_entry", {busy, show_prev, rd_addr}, 8'hC0);
        cnt = 0; cnt2 = 0; cnt3 = 0; last_copy = -1; first_eval = -1;
        for (int c = 0; c < 150; c++) begin
            cyc();
            if (copy_we) begin cnt++; last_copy = c; end
            if (eval_we) begin cnt2++; if (first_eval < 0) first_eval = c; end
            if (gen_done) cnt3++;
        end
        chk("copy_we_cycles", cnt, 64);
        chk("eval_we_cycles", cnt2, 64);
        chk("gen_done_pulses", cnt3, 1);
        chk("copy_before_eval", first_eval > last_copy, 1);
        chk("gen_count_first", gen_count, 1);
        pulse_tick(); wait_cyc(150);
        chk("gen_count_second", gen_count, 2);

        // divider, speed change and run drop
        do_reset();
        run = 1'b1; speed = 3'd3;
        for (int k = 0; k < 12; k++) begin pulse_tick(); wait_cyc(150); end
        chk("speed3_12ticks", gen_count, 3);
        speed = 3'd7;
        for (int k = 0; k < 3; k++) begin pulse_tick(); wait_cyc(5); end
        chk("speed7_no_gen", gen_count, 3);
        speed = 3'd1;
        pulse_tick(); wait_cyc(150);
        chk("speed_drop_fires", gen_count, 4);
        pulse_tick(); wait_cyc(5);
        chk("div_still_counting", busy, 0);
        pulse_tick(); run = 1'b0; wait_cyc(150);
        chk("run_drop_completes", gen_count, 5);
        for (int k = 0; k < 3; k++) begin pulse_tick(); wait_cyc(5); end
        chk("run0_div_stopped", {busy, gen_count}, 17'd5);

        // single steps, one dropped mid-EVAL
        do_reset();
        pulse_step(); wait_cyc(150);
        pulse_step(); wait_cyc(100);
        pulse_step();
        cnt = 0;
        for (int c = 0; c < 200; c++) begin cyc(); if (copy_we) cnt++; end
        chk("mid_eval_step_dropped", cnt, 0);
        chk("step_gen_count", gen_count, 2);

        // reset in the middle of an EVAL sweep
        do_reset();
        pulse_step(); wait_cyc(150);
        pulse_step();
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            cyc();
            if (eval_we && rd_addr == 6'd30) found = 1;
        end
        chk("reach_eval_addr30", found, 1);
        reset = 1'b1; cyc();
        chk("reset_mid_eval",
            {copy_we, eval_we, load_we, busy, show_prev, gen_done, rd_addr, wr_addr}, 0);
        chk("reset_gen_count", gen_count, 0);
        reset = 1'b0;
        cnt = 0;
        for (int c = 0; c < 150; c++) begin cyc(); if (copy_we || eval_we || load_we) cnt++; end
        chk("no_we_after_reset", cnt, 0);

        // load and step together: load wins, step not queued
        do_reset();
        pattern_sel = 2'd2; load = 1'b1; step = 1'b1; cyc(); load = 1'b0; step = 1'b0;
        cyc();
        chk("load_beats_step", {load_we, copy_we, busy}, 3'b101);
        cnt = 0;
        for (int c = 0; c < 150; c++) begin cyc(); if (copy_we) cnt++; end
        chk("step_not_queued", {cnt[15:0], gen_count}, 32'd0);
        pulse_step(); wait_cyc(150);
        chk("gen_after_load", gen_count, 1);

        chk("onehot_enables", onehot_viol, 0);
        chk("show_prev_during_gen", sp_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
